// File: rtl/jacobi_angle_arbiter_if.sv
// Request/result and pipeline-side signals of the Jacobi angle arbiter.
// The slave modport is the arbiter; the master modport is the array plus the
// shared angle pipeline that surround it.
interface jacobi_angle_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    logic [N_REQ-1:0]       req_vld_i;
    logic [N_REQ*WIDTH-1:0] req_x_i;
    logic [N_REQ*WIDTH-1:0] req_y_i;
    logic [N_REQ-1:0]       req_rdy_o;
    logic [WIDTH-1:0]       pipe_x_o;
    logic [WIDTH-1:0]       pipe_y_o;
    logic                   pipe_vld_o;
    logic [WIDTH-1:0]       pipe_angle_i;
    logic                   pipe_vld_i;
    logic [WIDTH-1:0]       res_angle_o;
    logic [N_REQ-1:0]       res_vld_o;
    logic                   err_o;

    modport master (
        output req_vld_i, req_x_i, req_y_i, pipe_angle_i, pipe_vld_i,
        input  req_rdy_o, pipe_x_o, pipe_y_o, pipe_vld_o, res_angle_o, res_vld_o, err_o
    );

    modport slave (
        input  req_vld_i, req_x_i, req_y_i, pipe_angle_i, pipe_vld_i,
        output req_rdy_o, pipe_x_o, pipe_y_o, pipe_vld_o, res_angle_o, res_vld_o, err_o
    );
endinterface

// File: rtl/jacobi_angle_arbiter.sv
// Round-robin arbiter sharing one fixed-latency vectoring-CORDIC angle pipeline
// between N_REQ requesters. Each issue is tagged in a latency-matched shift line
// so the returned angle is routed back to its originator. A drain window after
// reset discards stale pipeline output.
module jacobi_angle_arbiter #(
    parameter int N_REQ           = 4,
    parameter int WIDTH           = 16,
    parameter int PIPE_LATENCY    = 18,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    jacobi_angle_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(N_REQ);
    localparam int CW   = IDXW + 1;
    localparam int DRW  = $clog2(PIPE_LATENCY + 1);

    logic [IDXW-1:0]  rr_q, rr_d;
    logic [CW-1:0]    cand;
    logic [N_REQ-1:0] gnt;
    logic [IDXW-1:0]  gnt_idx;
    logic             xfer;
    logic [3:0]       outst_q [N_REQ];
    logic [DRW-1:0]   drain_q;
    logic [WIDTH-1:0] pipe_x_q, pipe_y_q;
    logic             pipe_vld_q;
    logic [IDXW-1:0]  issue_idx_q;
    logic             tag_vld_q [PIPE_LATENCY];
    logic [IDXW-1:0]  tag_idx_q [PIPE_LATENCY];
    logic             tail_vld;
    logic [IDXW-1:0]  tail_idx;
    logic             ret_live, ret_hit, ret_err;
    logic [N_REQ-1:0] res_vld_q, res_vld_d;
    logic [WIDTH-1:0] res_angle_q;
    logic             err_q;

    // Round-robin search for the first eligible requester from the pointer.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        xfer    = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + CW'(i);
            if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
            if (!xfer && !rst && bus.req_vld_i[cand[IDXW-1:0]] &&
                (outst_q[cand[IDXW-1:0]] < 4'(MAX_OUTSTANDING))) begin
                xfer    = 1'b1;
                gnt_idx = cand[IDXW-1:0];
            end
        end
        if (xfer) gnt[gnt_idx] = 1'b1;
        rr_d = rr_q;
        if (xfer) rr_d = (gnt_idx == IDXW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign tail_vld = tag_vld_q[PIPE_LATENCY-1];
    assign tail_idx = tag_idx_q[PIPE_LATENCY-1];
    assign ret_live = (drain_q == '0);
    assign ret_hit  = ret_live && bus.pipe_vld_i && tail_vld;
    assign ret_err  = ret_live && (bus.pipe_vld_i != tail_vld);

    // One-hot result valid for the tag at the tail.
    always_comb begin
        res_vld_d = '0;
        if (ret_hit) res_vld_d[tail_idx] = 1'b1;
    end

    // RR pointer, post-reset drain counter and registered issue stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            drain_q     <= DRW'(PIPE_LATENCY);
            pipe_vld_q  <= 1'b0;
            pipe_x_q    <= '0;
            pipe_y_q    <= '0;
            issue_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            pipe_vld_q <= xfer;
            if (drain_q != '0) drain_q <= drain_q - 1'b1;
            if (xfer) begin
                pipe_x_q    <= bus.req_x_i[gnt_idx*WIDTH +: WIDTH];
                pipe_y_q    <= bus.req_y_i[gnt_idx*WIDTH +: WIDTH];
                issue_idx_q <= gnt_idx;
            end
        end
    end

    // Tag line fed from the issue register, so its last stage lines up with pipe_vld_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PIPE_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= pipe_vld_q;
            tag_idx_q[0] <= issue_idx_q;
            for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    // Return stage: route matched angles, latch sticky mismatch error.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld_q   <= '0;
            res_angle_q <= '0;
            err_q       <= 1'b0;
        end else begin
            res_vld_q <= res_vld_d;
            if (ret_hit) res_angle_q <= bus.pipe_angle_i;
            if (ret_err) err_q <= 1'b1;
        end
    end

    // Per-requester in-flight counters; grant and return in one cycle cancel.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (rst) begin
                outst_q[k] <= '0;
            end else if (xfer && (gnt_idx == IDXW'(k)) &&
                         !(ret_hit && (tail_idx == IDXW'(k)))) begin
                outst_q[k] <= outst_q[k] + 1'b1;
            end else if (ret_hit && (tail_idx == IDXW'(k)) &&
                         !(xfer && (gnt_idx == IDXW'(k))) && (outst_q[k] != '0)) begin
                outst_q[k] <= outst_q[k] - 1'b1;
            end
        end
    end

    assign bus.req_rdy_o   = gnt;
    assign bus.pipe_x_o    = pipe_x_q;
    assign bus.pipe_y_o    = pipe_y_q;
    assign bus.pipe_vld_o  = pipe_vld_q;
    assign bus.res_angle_o = res_angle_q;
    assign bus.res_vld_o   = res_vld_q;
    assign bus.err_o       = err_q;
endmodule
